// File: rtl/wb_regfile_if.sv
// Writeback/register-file bus: MEM/WB writeback inputs, ID read ports,
// and the forwarding/commit outputs.
interface wb_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              wb_write_reg;
  logic [ADDR_W-1:0] wb_dst;
  logic              wb_mem_to_reg;
  logic [DATA_W-1:0] wb_alu_res;
  logic [DATA_W-1:0] wb_mem_data;
  logic [ADDR_W-1:0] rd1_addr;
  logic [ADDR_W-1:0] rd2_addr;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_commit;

  modport master (
    output wb_write_reg, wb_dst, wb_mem_to_reg,
    output wb_alu_res, wb_mem_data,
    output rd1_addr, rd2_addr,
    input  rd1_data, rd2_data, wb_data, wb_commit
  );

  modport slave (
    input  wb_write_reg, wb_dst, wb_mem_to_reg,
    input  wb_alu_res, wb_mem_data,
    input  rd1_addr, rd2_addr,
    output rd1_data, rd2_data, wb_data, wb_commit
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: R0 hardwired to zero,
// two read ports with same-cycle bypass of the retiring write.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  wb_regfile_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [1:NUM_REGS-1];
  logic [DATA_W-1:0] wdata;
  logic              wr_fire;
  logic              commit;

  assign wdata = bus.wb_mem_to_reg ? bus.wb_mem_data
                                   : bus.wb_alu_res;

  assign wr_fire = bus.wb_write_reg
                && (bus.wb_dst != '0)
                && rst_n;

  assign bus.wb_data   = wdata;
  assign bus.wb_commit = commit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      commit <= 1'b0;
    end else begin
      commit <= wr_fire;
      if (wr_fire) begin
        regs[bus.wb_dst] <= wdata;
      end
    end
  end

  // Bypass keys on wb_write_reg alone; R0 is caught first.
  always_comb begin
    bus.rd1_data = '0;
    if (bus.rd1_addr == '0) begin
      bus.rd1_data = '0;
    end else if (bus.wb_write_reg
                 && bus.wb_dst == bus.rd1_addr) begin
      bus.rd1_data = wdata;
    end else begin
      bus.rd1_data = regs[bus.rd1_addr];
    end
  end

  always_comb begin
    bus.rd2_data = '0;
    if (bus.rd2_addr == '0) begin
      bus.rd2_data = '0;
    end else if (bus.wb_write_reg
                 && bus.wb_dst == bus.rd2_addr) begin
      bus.rd2_data = wdata;
    end else begin
      bus.rd2_data = regs[bus.rd2_addr];
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a reference register model predicts
// every cycle's reads, writeback value and commit pulse.
module tb_wb_regfile;
  localparam int DW = 16;
  localparam int AW = 4;

  typedef struct {
    string       tag;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] wbd;
    logic        cm;
  } exp_t;

  logic clk;
  logic rst_n;

  wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nvec;
  int          nerr;
  exp_t        sb [$];
  logic [15:0] mregs [16];
  logic        mcommit;
  logic [15:0] o_rd1;
  logic [15:0] o_rd2;
  logic [15:0] o_wbd;
  logic        o_cm;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(
    input logic [3:0]  a,
    input logic        w,
    input logic [3:0]  dst,
    input logic [15:0] wbd
  );
    if (a == 4'd0) return 16'h0000;
    if (w && dst == a) return wbd;
    return mregs[a];
  endfunction

  task automatic step(input string       tag,
                      input logic        w,
                      input logic [3:0]  dst,
                      input logic        m2r,
                      input logic [15:0] alu,
                      input logic [15:0] mem,
                      input logic [3:0]  a1,
                      input logic [3:0]  a2,
                      input logic        rn);
    exp_t        e;
    exp_t        g;
    logic [15:0] wbd;
    @(negedge clk);
    bus.wb_write_reg  = w;
    bus.wb_dst        = dst;
    bus.wb_mem_to_reg = m2r;
    bus.wb_alu_res    = alu;
    bus.wb_mem_data   = mem;
    bus.rd1_addr      = a1;
    bus.rd2_addr      = a2;
    rst_n             = rn;
    wbd   = m2r ? mem : alu;
    e.tag = tag;
    e.rd1 = ref_rd(a1, w, dst, wbd);
    e.rd2 = ref_rd(a2, w, dst, wbd);
    e.wbd = wbd;
    e.cm  = mcommit;
    sb.push_back(e);
    #2;
    o_rd1 = bus.rd1_data;
    o_rd2 = bus.rd2_data;
    o_wbd = bus.wb_data;
    o_cm  = bus.wb_commit;
    g = sb.pop_front();
    chk({g.tag, ".rd1"}, o_rd1, g.rd1);
    chk({g.tag, ".rd2"}, o_rd2, g.rd2);
    chk({g.tag, ".wbd"}, o_wbd, g.wbd);
    chk({g.tag, ".cm"}, {15'd0, o_cm}, {15'd0, g.cm});
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < 16; i++) mregs[i] = 16'h0000;
      mcommit = 1'b0;
    end else begin
      mcommit = w && (dst != 4'd0);
      if (mcommit) mregs[dst] = wbd;
    end
  endtask

  initial begin
    nvec    = 0;
    nerr    = 0;
    mcommit = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0000;
    rst_n             = 1'b0;
    bus.wb_write_reg  = 1'b0;
    bus.wb_dst        = '0;
    bus.wb_mem_to_reg = 1'b0;
    bus.wb_alu_res    = '0;
    bus.wb_mem_data   = '0;
    bus.rd1_addr      = '0;
    bus.rd2_addr      = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      step("rst_rd", 1'b0, 4'd0, 1'b0, 16'h0, 16'h0,
           4'(i), 4'(15 - i), 1'b1);
      chk("rst_rd1", o_rd1, 16'h0000);
      chk("rst_rd2", o_rd2, 16'h0000);
    end
    chk("rst_cm", {15'd0, o_cm}, 16'h0000);

    step("byp", 1'b1, 4'd3, 1'b0, 16'hBEEF, 16'h0,
         4'd3, 4'd0, 1'b1);
    chk("byp_beef", o_rd1, 16'hBEEF);
    step("st3", 1'b0, 4'd3, 1'b0, 16'h0, 16'h0,
         4'd3, 4'd0, 1'b1);
    chk("st_beef", o_rd1, 16'hBEEF);
    chk("cm_pulse", {15'd0, o_cm}, 16'h0001);
    step("st3b", 1'b0, 4'd3, 1'b0, 16'h0, 16'h0,
         4'd3, 4'd3, 1'b1);
    chk("cm_once", {15'd0, o_cm}, 16'h0000);

    step("m2r", 1'b1, 4'd7, 1'b1, 16'h5555, 16'h1234,
         4'd0, 4'd1, 1'b1);
    chk("wbd_mem", o_wbd, 16'h1234);
    step("rd7", 1'b0, 4'd0, 1'b0, 16'h0, 16'h0,
         4'd3, 4'd7, 1'b1);
    chk("r7_mem", o_rd2, 16'h1234);

    step("r0w", 1'b1, 4'd0, 1'b0, 16'hFFFF, 16'h0,
         4'd0, 4'd0, 1'b1);
    chk("r0_same", o_rd1, 16'h0000);
    step("r0n", 1'b0, 4'd0, 1'b0, 16'hFFFF, 16'h0,
         4'd0, 4'd0, 1'b1);
    chk("r0_next", o_rd2, 16'h0000);
    chk("r0_nocm", {15'd0, o_cm}, 16'h0000);

    step("pre5", 1'b1, 4'd5, 1'b0, 16'h00AA, 16'h0,
         4'd0, 4'd0, 1'b1);
    step("nobyp", 1'b0, 4'd5, 1'b0, 16'h0055, 16'h0,
         4'd5, 4'd5, 1'b1);
    chk("nobyp1", o_rd1, 16'h00AA);
    chk("nobyp2", o_rd2, 16'h00AA);
    step("dbyp", 1'b1, 4'd5, 1'b0, 16'h0055, 16'h0,
         4'd5, 4'd5, 1'b1);
    chk("dbyp1", o_rd1, 16'h0055);
    chk("dbyp2", o_rd2, 16'h0055);

    step("ld9", 1'b1, 4'd9, 1'b0, 16'hCAFE, 16'h0,
         4'd0, 4'd0, 1'b1);
    step("rstw", 1'b1, 4'd9, 1'b0, 16'h1111, 16'h0,
         4'd9, 4'd5, 1'b0);
    step("prst", 1'b0, 4'd9, 1'b0, 16'h0, 16'h0,
         4'd9, 4'd5, 1'b1);
    chk("r9_clr", o_rd1, 16'h0000);
    chk("r5_clr", o_rd2, 16'h0000);
    chk("rst_nocm", {15'd0, o_cm}, 16'h0000);
    step("pw", 1'b1, 4'd9, 1'b1, 16'h0, 16'h2222,
         4'd0, 4'd0, 1'b1);
    step("pwr", 1'b0, 4'd0, 1'b0, 16'h0, 16'h0,
         4'd9, 4'd9, 1'b1);
    chk("post_w", o_rd1, 16'h2222);
    chk("post_cm", {15'd0, o_cm}, 16'h0001);

    for (int k = 0; k < 60; k++) begin
      step("rnd", 1'($urandom), 4'($urandom), 1'($urandom),
           16'($urandom), 16'($urandom),
           4'($urandom), 4'($urandom),
           ($urandom_range(0, 19) != 0));
    end

    chk("sb_empty", 16'(sb.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
